// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and constants for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {NORMAL, FORCE} state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// rtl/regfile_wb_arbiter_wb_fifo.sv - small synchronous FIFO holding aux writeback entries
module regfile_wb_arbiter_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write port arbiter: core priority, buffered aux, scoreboard
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_we,
  input  logic [REG_W-1:0]  core_rd,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_W-1:0]  aux_rd,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic              iss_valid,
  input  logic [REG_W-1:0]  iss_rd,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              core_stall,
  output logic [31:0]       busy,
  output logic              waw_err
);
  localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  state_t      state;
  logic [CW-1:0] starve_cnt;
  wb_entry_t   head;
  wb_entry_t   push_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        core_eff;
  logic        denied;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        waw_hit;

  assign push_entry = '{rd: aux_rd, data: aux_wdata};
  assign aux_ready  = !fifo_full;
  assign push       = aux_valid && !fifo_full;
  assign core_stall = (state == FORCE);

  regfile_wb_arbiter_wb_fifo #(
    .DEPTH(DEPTH),
    .W    (REG_W + DATA_W)
  ) u_wb_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .din  (push_entry),
    .pop  (pop),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Gating with reset keeps the write port quiet while reset is held.
  always_comb begin
    core_eff = !reset && (state == NORMAL) && core_we && (core_rd != REG_ZERO);
    pop      = !reset && !fifo_empty && ((state == FORCE) || !core_eff);
    denied   = core_eff && !fifo_empty;
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (core_eff) begin
      rf_we    = 1'b1;
      rf_waddr = core_rd;
      rf_wdata = core_wdata;
    end else if (pop && (head.rd != REG_ZERO)) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && (iss_rd != REG_ZERO)) set_mask = 32'd1 << iss_rd;
    if (pop && (head.rd != REG_ZERO))      clr_mask = 32'd1 << head.rd;
    waw_hit = (iss_valid && (iss_rd != REG_ZERO) && busy[iss_rd] && !clr_mask[iss_rd])
           || (core_eff && busy[core_rd]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      busy       <= '0;
      waw_err    <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          if (pop || fifo_empty) begin
            starve_cnt <= '0;
          end else if (denied) begin
            if (starve_cnt == CW'(STARVE_LIMIT - 1)) begin
              state      <= FORCE;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        FORCE: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
        default: state <= NORMAL;
      endcase
      // Set wins over clear when both hit the same register.
      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
      if (waw_hit) waw_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized self-checking bench with a queue-based reference model
module tb_regfile_wb_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wdata;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_wdata;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        core_stall;
  logic [31:0] busy;
  logic        waw_err;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_rd(core_rd), .core_wdata(core_wdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_wdata(aux_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .core_stall(core_stall), .busy(busy), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_force;
  int          m_starve;
  bit [31:0]   m_busy;
  bit          m_waw;
  bit          m_accepted;
  int          n_vec;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_force  = 0;
    m_starve = 0;
    m_busy   = '0;
    m_waw    = 0;
  endtask

  // One cycle: drive after the edge, compare mid-cycle, then advance the model.
  task automatic step(input bit cwe, input logic [4:0] crd, input logic [31:0] cwd,
                      input bit av, input logic [4:0] ard, input logic [31:0] awd,
                      input bit iv, input logic [4:0] ird);
    bit    eff, popped, e_we, e_ready, denied;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    ent_t  h;
    @(posedge clk);
    #1;
    core_we = cwe; core_rd = crd; core_wdata = cwd;
    aux_valid = av; aux_rd = ard; aux_wdata = awd;
    iss_valid = iv; iss_rd = ird;
    @(negedge clk);
    e_ready = (q.size() < DEPTH);
    eff     = !m_force && cwe && (crd != 0);
    popped  = 0; e_we = 0; e_addr = 0; e_data = 0;
    h.rd = 0; h.data = 0;
    if (eff) begin
      e_we = 1; e_addr = crd; e_data = cwd;
    end else if (q.size() > 0) begin
      popped = 1;
      h = q[0];
      if (h.rd != 0) begin
        e_we = 1; e_addr = h.rd; e_data = h.data;
      end
    end
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
    chk("rf_wdata", rf_wdata, e_data);
    chk("core_stall", {31'd0, core_stall}, {31'd0, m_force});
    chk("aux_ready", {31'd0, aux_ready}, {31'd0, e_ready});
    chk("busy", busy, m_busy);
    chk("waw_err", {31'd0, waw_err}, {31'd0, m_waw});

    if (iv && ird != 0 && m_busy[ird] && !(popped && h.rd == ird)) m_waw = 1;
    if (eff && m_busy[crd]) m_waw = 1;
    if (popped && h.rd != 0) m_busy[h.rd] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;

    denied = eff && (q.size() > 0);
    if (m_force) begin
      m_force = 0; m_starve = 0;
    end else if (popped || q.size() == 0) begin
      m_starve = 0;
    end else if (denied) begin
      if (m_starve == STARVE_LIMIT - 1) begin
        m_force = 1; m_starve = 0;
      end else begin
        m_starve++;
      end
    end

    if (popped) void'(q.pop_front());
    m_accepted = av && e_ready;
    if (m_accepted) q.push_back('{rd: ard, data: awd});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset is raised and dropped away from the clock edge; a pending core write must be blocked.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1; core_we = 1; core_rd = 5'd5; core_wdata = 32'h1234_5678;
    aux_valid = 0; iss_valid = 0;
    @(negedge clk);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_aux_ready", {31'd0, aux_ready}, 32'd1);
    chk("rst_busy", busy, 32'd0);
    chk("rst_waw", {31'd0, waw_err}, 32'd0);
    chk("rst_stall", {31'd0, core_stall}, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 0; core_we = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1; core_we = 0; core_rd = 0; core_wdata = 0;
    aux_valid = 0; aux_rd = 0; aux_wdata = 0; iss_valid = 0; iss_rd = 0;
    model_clear();
    do_reset();

    // Aux only, with busy[8] reserved beforehand
    step(0, 0, 0, 0, 0, 0, 1, 5'd8);
    step(0, 0, 0, 1, 5'd8, 32'hDEADBEEF, 0, 0);
    idle();
    chk("aux_we", {31'd0, rf_we}, 32'd1);
    chk("aux_addr", {27'd0, rf_waddr}, 32'd8);
    chk("aux_data", rf_wdata, 32'hDEADBEEF);
    chk("aux_busy_pre", {31'd0, busy[8]}, 32'd1);
    idle();
    chk("aux_busy_post", {31'd0, busy[8]}, 32'd0);

    // Core priority over a waiting head
    step(0, 0, 0, 1, 5'd3, 32'h33, 0, 0);
    step(1, 5'd5, 32'h11, 0, 0, 0, 0, 0);
    chk("prio_addr", {27'd0, rf_waddr}, 32'd5);
    chk("prio_data", rf_wdata, 32'h11);
    idle();
    chk("prio_aux_addr", {27'd0, rf_waddr}, 32'd3);

    // Starvation forces one drain cycle
    step(0, 0, 0, 1, 5'd7, 32'h77, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    step(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    chk("starve_stall", {31'd0, core_stall}, 32'd1);
    chk("starve_addr", {27'd0, rf_waddr}, 32'd7);
    step(1, 5'd9, 32'h99, 0, 0, 0, 0, 0);
    chk("starve_release", {31'd0, core_stall}, 32'd0);
    chk("starve_core_addr", {27'd0, rf_waddr}, 32'd9);

    // Fill under core pressure, third entry waits for a pop
    step(1, 5'd10, 32'hA, 1, 5'd20, 32'h20, 0, 0);
    step(1, 5'd10, 32'hA, 1, 5'd21, 32'h21, 0, 0);
    step(1, 5'd10, 32'hA, 1, 5'd22, 32'h22, 0, 0);
    chk("full_ready", {31'd0, aux_ready}, 32'd0);
    m_accepted = 0;
    for (int i = 0; i < 10 && !m_accepted; i++) step(1, 5'd10, 32'hA, 1, 5'd22, 32'h22, 0, 0);
    chk("full_accept_bound", {31'd0, m_accepted}, 32'd1);
    for (int i = 0; i < 4; i++) idle();

    // $0 handling
    step(0, 0, 0, 1, 5'd4, 32'h44, 0, 0);
    step(1, 5'd0, 32'hFF, 0, 0, 0, 0, 0);
    chk("zero_core_we", {31'd0, rf_we}, 32'd1);
    chk("zero_core_addr", {27'd0, rf_waddr}, 32'd4);
    step(0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
    idle();
    chk("zero_aux_we", {31'd0, rf_we}, 32'd0);
    chk("zero_busy", busy, 32'd0);

    // Scoreboard WAW and reset recovery
    step(0, 0, 0, 0, 0, 0, 1, 5'd12);
    step(1, 5'd12, 32'h5, 0, 0, 0, 0, 0);
    idle();
    chk("waw_set", {31'd0, waw_err}, 32'd1);
    idle();
    chk("waw_sticky", {31'd0, waw_err}, 32'd1);
    step(1, 5'd6, 32'h6, 1, 5'd13, 32'h13, 1, 5'd14);
    do_reset();
    idle();
    chk("post_rst_we", {31'd0, rf_we}, 32'd0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < 55,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             $urandom_range(0, 99) < 50,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom,
             $urandom_range(0, 99) < 20,
             5'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
